// File: rtl/decode_5to32_acc.sv
// Accumulating 5-to-32 decoder: ORs one-hot decoded codes into a mask, emits mask + distinct-bit count on last.
// Latency: final mask valid one cycle after the last code is accepted. Backpressure: in_ready drops while the mask is held.
// Optional macro DECODE_TOP_EN adds out_top, the index of the highest set mask bit.
module decode_5to32_acc #(
    parameter int IN_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [IN_W-1:0]       in_code,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [(2**IN_W)-1:0]  out_mask,
`ifdef DECODE_TOP_EN
    output logic [IN_W-1:0]       out_top,
`endif
    output logic [IN_W:0]         out_count
);

    localparam int MW = 2**IN_W;
    localparam int CW = IN_W + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        OUTPUT = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [MW-1:0]   acc;
    logic [CW-1:0]   cnt;
    logic            accept;
    logic            handshake;

    assign accept    = in_valid && in_ready;
    assign handshake = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, ACCUM: begin
                if (accept) begin
                    state_nxt = in_last ? OUTPUT : ACCUM;
                end
            end
            OUTPUT: begin
                if (handshake) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake flags depend on state only, so there is no out_ready -> in_ready path.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE, ACCUM: in_ready  = 1'b1;
            OUTPUT:      out_valid = 1'b1;
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            cnt <= '0;
        end else if (handshake) begin
            acc <= '0;
            cnt <= '0;
        end else if (accept && en) begin
            acc[in_code] <= 1'b1;
            // Duplicate codes leave the distinct-bit count unchanged.
            if (!acc[in_code]) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign out_mask  = out_valid ? acc : '0;
    assign out_count = out_valid ? cnt : '0;

`ifdef DECODE_TOP_EN
    logic [IN_W-1:0] top;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            top <= '0;
        end else if (handshake) begin
            top <= '0;
        end else if (accept && en && (in_code > top)) begin
            top <= in_code;
        end
    end

    assign out_top = out_valid ? top : '0;
`endif

endmodule
